// File: rtl/vram_arbiter.sv
// Arbitrates the single-port video/work RAM between the raster fetcher (priority)
// and the CPU bus, with a one-entry video read latch and a CPU starvation guard.
module vram_arbiter #(
    parameter int RAM_SIZE       = 8192,
    parameter int RAM_ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int XLEN           = 8,
    parameter int STARVE_LIMIT   = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      vid_req,
    input  logic [RAM_ADDR_WIDTH-1:0] vid_addr,
    output logic [XLEN-1:0]           vid_data,
    output logic                      vid_valid,
    output logic                      vid_drop,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [RAM_ADDR_WIDTH-1:0] cpu_addr,
    input  logic [XLEN-1:0]           cpu_wdata,
    output logic [XLEN-1:0]           cpu_rdata,
    output logic                      cpu_ack,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic                      ram_we,
    output logic [XLEN-1:0]           ram_wdata,
    input  logic [XLEN-1:0]           ram_rdata
);

    localparam int              WAIT_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);
    localparam bit              FORCE_EN = (STARVE_LIMIT != 0);

    typedef enum logic [1:0] {C_IDLE, C_RD, C_DONE} cpu_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_t;

    cpu_state_t                state;
    logic [WAIT_W-1:0]         wait_cnt;

    logic                      lat_valid;
    logic [RAM_ADDR_WIDTH-1:0] lat_tag;
    logic [XLEN-1:0]           lat_data;

    // Owner pipeline: own_now is who drives the port this cycle, own_rd tags
    // the ram_rdata returning in the following cycle.
    owner_t                    own_now;
    owner_t                    own_rd;

    logic                      s1_hit;
    logic                      s1_drop;
    logic [RAM_ADDR_WIDTH-1:0] s1_addr;
    logic [XLEN-1:0]           s1_data;

    logic wr_conflict;
    logic vid_hit;
    logic vid_miss;
    logic cpu_idle_req;
    logic forced;
    logic grant_vid;
    logic grant_cpu;
    logic cpu_wr;

    // A same-cycle CPU write to the fetched address must not be bypassed by
    // stale latch data, so it degrades the hit to a RAM read.
    assign wr_conflict  = cpu_req & cpu_we & (cpu_addr == vid_addr);
    assign vid_hit      = vid_req & lat_valid & (vid_addr == lat_tag) & ~wr_conflict;
    assign vid_miss     = vid_req & ~vid_hit;
    assign cpu_idle_req = (state == C_IDLE) & cpu_req;
    assign forced       = FORCE_EN & cpu_idle_req & (wait_cnt == WAIT_MAX);
    assign grant_vid    = vid_miss & ~forced;
    assign grant_cpu    = forced | (cpu_idle_req & ~vid_miss);
    assign cpu_wr       = grant_cpu & cpu_we;

    assign ram_addr  = grant_cpu ? cpu_addr : vid_addr;
    assign ram_we    = cpu_wr;
    assign ram_wdata = cpu_wdata;

    always_comb begin
        own_now = OWN_NONE;
        if (grant_cpu) begin
            if (!cpu_we) own_now = OWN_CPU;
        end else if (grant_vid) begin
            own_now = OWN_VID;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            own_rd <= OWN_NONE;
        end else begin
            own_rd <= own_now;
        end
    end

    // Video return path: hits and misses both emerge two cycles after request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_hit    <= 1'b0;
            s1_drop   <= 1'b0;
            s1_addr   <= '0;
            s1_data   <= '0;
            vid_valid <= 1'b0;
            vid_drop  <= 1'b0;
            vid_data  <= '0;
        end else begin
            s1_hit  <= vid_hit;
            s1_drop <= vid_miss & forced;
            if (grant_vid) s1_addr <= vid_addr;
            if (vid_hit)   s1_data <= lat_data;

            vid_valid <= s1_hit | (own_rd == OWN_VID);
            vid_drop  <= s1_drop;
            if (own_rd == OWN_VID)
                vid_data <= ram_rdata;
            else if (s1_hit)
                vid_data <= s1_data;
        end
    end

    // Latch fill races a CPU write granted in the fill cycle; the write wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_valid <= 1'b0;
            lat_tag   <= '0;
            lat_data  <= '0;
        end else if (own_rd == OWN_VID) begin
            lat_tag   <= s1_addr;
            lat_data  <= ram_rdata;
            lat_valid <= ~(cpu_wr & (cpu_addr == s1_addr));
        end else if (cpu_wr & (cpu_addr == lat_tag)) begin
            lat_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= C_IDLE;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            wait_cnt  <= '0;
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                C_IDLE: begin
                    if (grant_cpu) begin
                        if (cpu_we) begin
                            state   <= C_DONE;
                            cpu_ack <= 1'b1;
                        end else begin
                            state <= C_RD;
                        end
                    end
                end
                C_RD: begin
                    if (own_rd == OWN_CPU) cpu_rdata <= ram_rdata;
                    state   <= C_DONE;
                    cpu_ack <= 1'b1;
                end
                C_DONE:  state <= C_IDLE;
                default: state <= C_IDLE;
            endcase

            if (!cpu_req || grant_cpu)
                wait_cnt <= '0;
            else if (state == C_IDLE && wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: stimulus pushes expected video/CPU responses,
// a forked monitor pops and compares them when the DUT presents an output.
module tb_vram_arbiter;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_data;
    logic          vid_valid;
    logic          vid_drop;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic [7:0]    cpu_rdata;
    logic          cpu_ack;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    vram_arbiter #(.RAM_SIZE(8192), .XLEN(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_valid(vid_valid), .vid_drop(vid_drop),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: unwritten bytes read as addr[7:0] ^ 8'h5A.
    logic [7:0] mem [8192];
    bit         wr_seen [8192];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            wr_seen[ram_addr] <= 1'b1;
        end
        ram_rdata <= wr_seen[ram_addr] ? mem[ram_addr] : (ram_addr[7:0] ^ 8'h5A);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; bit drop; logic [7:0] data; } vexp_t;
    typedef struct { int cyc; bit rd;   logic [7:0] data; } cexp_t;
    vexp_t vq[$];
    cexp_t cq[$];

    int checks   = 0;
    int failures = 0;

    task automatic exp_vid(input int c, input bit drop, input logic [7:0] d);
        vexp_t e;
        e.cyc = c; e.drop = drop; e.data = d;
        vq.push_back(e);
    endtask

    task automatic exp_cpu(input int c, input bit rd, input logic [7:0] d);
        cexp_t e;
        e.cyc = c; e.rd = rd; e.data = d;
        cq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
        end
    endtask

    task automatic monitor();
        vexp_t v;
        cexp_t c;
        forever begin
            @(negedge clk);
            if (vid_valid || vid_drop) begin
                checks++;
                if (vq.size() == 0) begin
                    failures++;
                    $display("FAIL vid_unexpected cyc=%0d valid=%0b drop=%0b data=%h",
                             cyc, vid_valid, vid_drop, vid_data);
                end else begin
                    v = vq.pop_front();
                    if (cyc != v.cyc || vid_valid != !v.drop || vid_drop != v.drop || vid_data !== v.data) begin
                        failures++;
                        $display("FAIL vid_out got cyc=%0d valid=%0b drop=%0b data=%h want cyc=%0d drop=%0b data=%h",
                                 cyc, vid_valid, vid_drop, vid_data, v.cyc, v.drop, v.data);
                    end
                end
            end
            if (cpu_ack) begin
                checks++;
                if (cq.size() == 0) begin
                    failures++;
                    $display("FAIL cpu_unexpected_ack cyc=%0d rdata=%h", cyc, cpu_rdata);
                end else begin
                    c = cq.pop_front();
                    if (cyc != c.cyc || (c.rd && cpu_rdata !== c.data)) begin
                        failures++;
                        $display("FAIL cpu_ack got cyc=%0d rdata=%h want cyc=%0d rd=%0b rdata=%h",
                                 cyc, cpu_rdata, c.cyc, c.rd, c.data);
                    end
                end
            end
        end
    endtask

    // One cycle forward; a CPU that sees its ack releases the request.
    task automatic step();
        @(posedge clk);
        #1;
        if (cpu_ack) cpu_req = 1'b0;
    endtask

    logic [AW-1:0] t2a [3] = '{13'h041F, 13'h043F, 13'h045F};
    logic [7:0]    t2d [3] = '{8'h45, 8'h65, 8'h05};
    logic [7:0]    t4d [8] = '{8'h5A, 8'h5B, 8'h58, 8'h59, 8'h00, 8'h5F, 8'h5C, 8'h5D};

    initial begin
        int n;
        rst_n = 1'b0; vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        fork
            monitor();
        join_none
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("reset_outputs", {11'd0, vid_valid, vid_drop, cpu_ack, vid_data, cpu_rdata}, 32'd0);
        chk("reset_ram_we", {31'd0, ram_we}, 32'd0);

        // CPU write then read-back with video idle
        step(); n = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0400; cpu_wdata = 8'hA5;
        #1 chk("t1_wr_grant", {10'd0, ram_we, ram_addr, ram_wdata}, {10'd0, 1'b1, 13'h0400, 8'hA5});
        exp_cpu(n + 1, 1'b0, 8'h00);
        step(); step(); n = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0400;
        #1 chk("t1_rd_grant", {18'd0, ram_we, ram_addr}, {18'd0, 1'b0, 13'h0400});
        exp_cpu(n + 2, 1'b1, 8'hA5);
        repeat (3) step();

        // back-to-back video misses
        for (int i = 0; i < 3; i++) begin
            step();
            vid_req = 1'b1; vid_addr = t2a[i];
            #1 chk("t2_ram_port", {18'd0, ram_we, ram_addr}, {18'd0, 1'b0, t2a[i]});
            exp_vid(cyc + 2, 1'b0, t2d[i]);
        end
        step(); vid_req = 1'b0;
        step(); step();

        // CPU read served while video hits the latch
        step(); n = cyc;
        vid_req = 1'b1; vid_addr = 13'h045F;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
        #1 chk("t3_cpu_grant", {18'd0, ram_we, ram_addr}, {18'd0, 1'b0, 13'h0123});
        exp_cpu(n + 2, 1'b1, 8'h79);
        exp_vid(n + 2, 1'b0, 8'h05);
        for (int i = 1; i < 8; i++) begin
            step();
            exp_vid(cyc + 2, 1'b0, 8'h05);
        end
        step(); vid_req = 1'b0;
        step(); step();

        // starvation guard with continuous misses
        step(); n = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0200;
        vid_req = 1'b1; vid_addr = 13'h0600;
        exp_vid(n + 2, 1'b0, t4d[0]);
        exp_cpu(n + 6, 1'b1, 8'h5A);
        for (int i = 1; i < 8; i++) begin
            step();
            vid_addr = 13'h0600 + 13'(i);
            #1;
            if (i == 3) chk("t4_still_waiting", {19'd0, ram_addr}, {19'd0, 13'h0603});
            if (i == 4) begin
                chk("t4_forced_grant", {19'd0, ram_addr}, {19'd0, 13'h0200});
                exp_vid(cyc + 2, 1'b1, 8'h59);
            end else begin
                exp_vid(cyc + 2, 1'b0, t4d[i]);
            end
        end
        step(); vid_req = 1'b0;
        step(); step();

        // write/fetch conflict on the latched address
        step(); n = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h041F; cpu_wdata = 8'h11;
        exp_cpu(n + 1, 1'b0, 8'h00);
        step(); step();
        vid_req = 1'b1; vid_addr = 13'h041F;
        exp_vid(cyc + 2, 1'b0, 8'h11);
        step(); vid_req = 1'b0;
        step(); step();
        step(); n = cyc;
        vid_req = 1'b1; vid_addr = 13'h041F;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h041F; cpu_wdata = 8'h22;
        #1 chk("t5_conflict_vid_wins", {18'd0, ram_we, ram_addr}, {18'd0, 1'b0, 13'h041F});
        exp_vid(n + 2, 1'b0, 8'h11);
        exp_cpu(n + 2, 1'b0, 8'h00);
        step(); vid_req = 1'b0;
        #1 chk("t5_cpu_commit", {10'd0, ram_we, ram_addr, ram_wdata}, {10'd0, 1'b1, 13'h041F, 8'h22});
        step(); step();
        vid_req = 1'b1; vid_addr = 13'h041F;
        exp_vid(cyc + 2, 1'b0, 8'h22);
        step(); vid_req = 1'b0;
        step(); step();

        // reset while a CPU read sits in C_RD
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0400;
        step();
        rst_n = 1'b0; cpu_req = 1'b0; vid_req = 1'b1; vid_addr = 13'h0300;
        step();
        vid_req = 1'b0;
        #1 chk("t6_reset_clears", {11'd0, vid_valid, vid_drop, cpu_ack, vid_data, cpu_rdata}, 32'd0);
        step();
        rst_n = 1'b1;
        step(); n = cyc;
        vid_req = 1'b1; vid_addr = 13'h041F;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0400;
        #1 chk("t6_first_fetch_miss", {19'd0, ram_addr}, {19'd0, 13'h041F});
        exp_vid(n + 2, 1'b0, 8'h22);
        exp_cpu(n + 3, 1'b1, 8'hA5);
        step(); vid_req = 1'b0;
        repeat (6) step();

        chk("vid_queue_drained", 32'(vq.size()), 32'd0);
        chk("cpu_queue_drained", 32'(cq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 8K video/work RAM between the raster video fetcher and the CPU bus.
- Video has priority. A one-entry read latch serves repeated video addresses without using the RAM port.
- The CPU is served in free slots; a starvation guard forces a CPU slot after a bounded wait.
- Sits between the CPU memory decoder, the video unit and the synchronous-read RAM macro.

Parameters:
- RAM_SIZE, 8192, RAM depth in bytes.
- RAM_ADDR_WIDTH, $clog2(RAM_SIZE), address width.
- XLEN, 8, data width.
- STARVE_LIMIT, 64, CPU wait cycles before a forced grant; 0 disables forcing.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- vid_req  in  1  video fetch request, one per cycle; no handshake.
- vid_addr  in  RAM_ADDR_WIDTH  video fetch address.
- vid_data  out  XLEN  fetched byte; valid while vid_valid.
- vid_valid  out  1  pulse, exactly 2 cycles after an accepted vid_req.
- vid_drop  out  1  pulse, 2 cycles after a vid_req lost to a forced CPU grant.
- cpu_req  in  1  CPU request; held with addr/we/wdata stable until cpu_ack.
- cpu_we  in  1  1 = write.
- cpu_addr  in  RAM_ADDR_WIDTH  CPU address.
- cpu_wdata  in  XLEN  write data.
- cpu_rdata  out  XLEN  read data; valid while cpu_ack on a read.
- cpu_ack  out  1  one-cycle completion pulse.
- ram_addr  out  RAM_ADDR_WIDTH  RAM address, combinational from the grant.
- ram_we  out  1  RAM write enable, combinational from the grant.
- ram_wdata  out  XLEN  RAM write data.
- ram_rdata  in  XLEN  RAM read data, valid the cycle after the address is presented with ram_we=0.

Behaviour:
- Reset: every output register clears to 0; vid_valid, vid_drop and cpu_ack are 0. The latch is invalidated, the FSM goes to C_IDLE and the wait counter clears. In-flight transactions are discarded; no ack or valid is issued for them.
- Video hit: vid_req and latch valid and vid_addr == latch tag. It is not a hit if cpu_req & cpu_we & cpu_addr == vid_addr in the same cycle; that case is a miss.
- Grant, per cycle N:
  - Forced: C_IDLE & cpu_req & wait counter == STARVE_LIMIT (STARVE_LIMIT != 0) → CPU granted.
  - Video miss, not forced → video granted.
  - Otherwise C_IDLE & cpu_req → CPU granted.
  - No grant → ram_addr = vid_addr, ram_we = 0.
- Video pipeline:
  - Miss granted at N: ram_rdata is captured into vid_data and the latch (tag = address) at the end of N+1; vid_valid = 1 in N+2.
  - Hit at N: the latch data is copied into vid_data; vid_valid = 1 in N+2. Fixed latency 2 for every accepted request.
  - Miss lost to a forced grant at N: vid_valid = 0 and vid_drop = 1 in N+2; vid_data is held.
  - A 2-stage owner pipeline tags each returning ram_rdata as video or CPU.
- CPU FSM:
  - C_IDLE: on a grant, write → ram_we = 1 with cpu_wdata, go to C_DONE; read → go to C_RD.
  - C_RD: capture ram_rdata into cpu_rdata at the end of the cycle, go to C_DONE. The RAM port is free for video during this state.
  - C_DONE: cpu_ack = 1, go to C_IDLE. cpu_req is ignored in this cycle, so there is no double service.
  - Latency from grant to ack: write 1 cycle, read 2 cycles.
- Coherency: a CPU write to an address equal to the latch tag invalidates the latch at that edge.
- Wait counter:
  - Increments each C_IDLE cycle with cpu_req high and no CPU grant; saturates at STARVE_LIMIT.
  - Clears on CPU grant or when cpu_req is low.
  - Width is $clog2(STARVE_LIMIT+1), minimum 1.
- Video never stalls: vid_req is accepted every cycle except on a forced CPU grant. Back-to-back pipelines overlap.

Test Plan:
- Idle video, CPU writes 0xA5 to 0x0400, then reads 0x0400 → write ack 1 cycle after grant; read ack 2 cycles after grant with cpu_rdata = 0xA5.
- vid_req every cycle, addresses 0x041F, 0x043F, 0x045F (all misses) → vid_valid in N+2 each cycle with the matching RAM bytes; ram_we stays 0.
- CPU read pending while video hits the same address for 8 cycles → CPU granted in the first hit cycle; video output stays continuous.
- Continuous video misses with STARVE_LIMIT = 4 and cpu_req held → CPU granted in the 5th cycle of waiting; vid_drop pulses 2 cycles later; counter back to 0.
- Latch holds 0x041F = 0x11; CPU writes 0x22 to 0x041F during a video request for 0x041F → treated as a miss, video wins and returns 0x11; CPU write commits next cycle; the next video fetch of 0x041F misses and returns 0x22.
- rst_n low during C_RD → no cpu_ack; all outputs 0 the cycle after reset; first video fetch after reset is a miss.
